// File: rtl/exe_writeback_if.sv
// ALU-to-writeback result bus: one completed ALU result per valid cycle.
// Latency: none, wires only.
// Backpressure: mem_blocked flows back to the ALU, which stops issuing one cycle later.
interface exe_writeback_if;
  logic         exe_valid;
  logic [127:0] exe_result;
  logic [63:0]  exe_rflags;
  logic [3:0]   exe_dest;
  logic         exe_dest_we;
  logic         exe_wide;
  logic [3:0]   exe_dest2;
  logic         exe_flags_we;
  logic         mem_blocked;

  // ALU side drives results and observes backpressure
  modport master (
    output exe_valid, exe_result, exe_rflags, exe_dest, exe_dest_we,
           exe_wide, exe_dest2, exe_flags_we,
    input  mem_blocked
  );

  // Writeback side consumes results and produces backpressure
  modport slave (
    input  exe_valid, exe_result, exe_rflags, exe_dest, exe_dest_we,
           exe_wide, exe_dest2, exe_flags_we,
    output mem_blocked
  );
endinterface

// File: rtl/exe_writeback.sv
// Buffers ALU results and retires them through one 64-bit GPR write port plus RFLAGS.
// Latency: push at edge E -> strobes after E+1; retire after E+2 (narrow) or E+3 (wide).
// Backpressure: mem_blocked = count >= DEPTH-1, leaving room for the one in-flight ALU result.
module exe_writeback #(
  parameter int DEPTH = 2,
  parameter int CW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  exe_writeback_if.slave      ex,
  output logic                gpr_we,
  output logic [3:0]          gpr_waddr,
  output logic [63:0]         gpr_wdata,
  output logic                rflags_we,
  output logic [63:0]         rflags_wdata,
  output logic                retire,
  output logic                overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [127:0] result;
    logic [63:0]  rflags;
    logic [3:0]   dest;
    logic         dest_we;
    logic         wide;
    logic [3:0]   dest2;
    logic         flags_we;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_inc, rptr_inc;
  logic [CW-1:0] count;
  logic          push, pop;
  state_t        state, state_nxt;
  entry_t        head, next_head, lo_src;
  logic          load_lo;

  logic          gpr_we_nxt, rflags_we_nxt, retire_nxt;
  logic [3:0]    gpr_waddr_nxt;
  logic [63:0]   gpr_wdata_nxt, rflags_wdata_nxt;

  assign push           = ex.exe_valid && (count < CW'(DEPTH));
  assign ex.mem_blocked = (count >= CW'(DEPTH - 1));
  assign wptr_inc       = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
  assign rptr_inc       = (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
  assign head           = mem[rptr];
  assign next_head      = mem[rptr_inc];

  // Capture accepted ALU results into the entry at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{result:   ex.exe_result,
                     rflags:   ex.exe_rflags,
                     dest:     ex.exe_dest,
                     dest_we:  ex.exe_dest_we,
                     wide:     ex.exe_wide,
                     dest2:    ex.exe_dest2,
                     flags_we: ex.exe_flags_we};
    end
  end

  // Pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr_inc;
      if (pop)  rptr <= rptr_inc;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ex.exe_valid && (count == CW'(DEPTH))) overflow <= 1'b1;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM next state, pop decision and next write-port values
  always_comb begin
    state_nxt        = state;
    pop              = 1'b0;
    load_lo          = 1'b0;
    lo_src           = head;
    gpr_we_nxt       = 1'b0;
    gpr_waddr_nxt    = '0;
    gpr_wdata_nxt    = '0;
    rflags_we_nxt    = 1'b0;
    rflags_wdata_nxt = '0;
    retire_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (count != '0) begin
          load_lo   = 1'b1;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (head.wide) begin
          gpr_we_nxt    = 1'b1;
          gpr_waddr_nxt = head.dest2;
          gpr_wdata_nxt = head.result[127:64];
          state_nxt     = HIGH;
        end else begin
          pop = 1'b1;
        end
      end
      HIGH:    pop = 1'b1;
      default: state_nxt = IDLE;
    endcase

    // Retiring the head: chain straight into the next stored entry if any.
    // An entry pushed on this same edge is not yet readable and is picked up from IDLE.
    if (pop) begin
      retire_nxt = 1'b1;
      if (count > CW'(1)) begin
        load_lo   = 1'b1;
        lo_src    = next_head;
        state_nxt = LOW;
      end else begin
        state_nxt = IDLE;
      end
    end

    if (load_lo) begin
      gpr_we_nxt       = lo_src.dest_we;
      gpr_waddr_nxt    = lo_src.dest;
      gpr_wdata_nxt    = lo_src.result[63:0];
      rflags_we_nxt    = lo_src.flags_we;
      rflags_wdata_nxt = lo_src.rflags;
    end
  end

  // Registered write port and retire pulse, each held for exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_we       <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      rflags_we    <= 1'b0;
      rflags_wdata <= '0;
      retire       <= 1'b0;
    end else begin
      gpr_we       <= gpr_we_nxt;
      gpr_waddr    <= gpr_waddr_nxt;
      gpr_wdata    <= gpr_wdata_nxt;
      rflags_we    <= rflags_we_nxt;
      rflags_wdata <= rflags_wdata_nxt;
      retire       <= retire_nxt;
    end
  end

endmodule

// File: tb/tb_exe_writeback.sv
// Directed bench for exe_writeback with DEPTH=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Every scenario task checks its own expected values inline.
module tb_exe_writeback;
  logic        clk = 1'b0;
  logic        reset;
  logic        gpr_we, rflags_we, retire, overflow;
  logic [3:0]  gpr_waddr;
  logic [63:0] gpr_wdata, rflags_wdata;
  int          checks = 0;
  int          errors = 0;

  exe_writeback_if ex();

  exe_writeback #(.DEPTH(2), .CW(3)) dut (
    .clk(clk), .reset(reset), .ex(ex),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .rflags_we(rflags_we), .rflags_wdata(rflags_wdata),
    .retire(retire), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] res, input logic [63:0] fl, input logic [3:0] d,
                       input logic dwe, input logic w, input logic [3:0] d2, input logic fwe);
    ex.exe_valid    = 1'b1;
    ex.exe_result   = res;
    ex.exe_rflags   = fl;
    ex.exe_dest     = d;
    ex.exe_dest_we  = dwe;
    ex.exe_wide     = w;
    ex.exe_dest2    = d2;
    ex.exe_flags_we = fwe;
  endtask

  task automatic idle_in();
    ex.exe_valid    = 1'b0;
    ex.exe_result   = '0;
    ex.exe_rflags   = '0;
    ex.exe_dest     = '0;
    ex.exe_dest_we  = 1'b0;
    ex.exe_wide     = 1'b0;
    ex.exe_dest2    = '0;
    ex.exe_flags_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_in(); tick(); tick();
    checks++; if (gpr_we !== 1'b0 || rflags_we !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL reset_strobes: we=%b rfwe=%b ret=%b required 0 0 0", gpr_we, rflags_we, retire); end
    checks++; if (gpr_waddr !== 4'd0 || gpr_wdata !== 64'd0 || rflags_wdata !== 64'd0) begin errors++; $display("FAIL reset_data: addr=%h data=%h rf=%h required 0", gpr_waddr, gpr_wdata, rflags_wdata); end
    checks++; if (overflow !== 1'b0 || ex.mem_blocked !== 1'b0) begin errors++; $display("FAIL reset_flags: ovf=%b blk=%b required 0 0", overflow, ex.mem_blocked); end
    reset = 1'b0; tick();
  endtask

  task automatic test_narrow();
    drive(128'h1234, 64'h46, 4'd3, 1'b1, 1'b0, 4'd0, 1'b1); tick(); idle_in();
    checks++; if (gpr_we !== 1'b0 || ex.mem_blocked !== 1'b1) begin errors++; $display("FAIL narrow_e0: we=%b blk=%b required 0 1", gpr_we, ex.mem_blocked); end
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd3 || gpr_wdata !== 64'h1234) begin errors++; $display("FAIL narrow_write: we=%b addr=%h data=%h required 1 3 1234", gpr_we, gpr_waddr, gpr_wdata); end
    checks++; if (rflags_we !== 1'b1 || rflags_wdata !== 64'h46 || retire !== 1'b0) begin errors++; $display("FAIL narrow_flags: rfwe=%b rf=%h ret=%b required 1 46 0", rflags_we, rflags_wdata, retire); end
    tick();
    checks++; if (retire !== 1'b1 || gpr_we !== 1'b0 || rflags_we !== 1'b0 || ex.mem_blocked !== 1'b0) begin errors++; $display("FAIL narrow_retire: ret=%b we=%b rfwe=%b blk=%b required 1 0 0 0", retire, gpr_we, rflags_we, ex.mem_blocked); end
    tick();
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL narrow_retire_len: ret=%b required 0", retire); end
  endtask

  task automatic test_wide();
    drive({64'hAAAABBBB, 64'hCCCC}, 64'h5, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1); tick(); idle_in();
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd0 || gpr_wdata !== 64'hCCCC || rflags_we !== 1'b1 || rflags_wdata !== 64'h5) begin errors++; $display("FAIL wide_low: we=%b addr=%h data=%h rfwe=%b rf=%h required 1 0 cccc 1 5", gpr_we, gpr_waddr, gpr_wdata, rflags_we, rflags_wdata); end
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd2 || gpr_wdata !== 64'hAAAABBBB || rflags_we !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL wide_high: we=%b addr=%h data=%h rfwe=%b ret=%b required 1 2 aaaabbbb 0 0", gpr_we, gpr_waddr, gpr_wdata, rflags_we, retire); end
    checks++; if (ex.mem_blocked !== 1'b1) begin errors++; $display("FAIL wide_blocked: blk=%b required 1", ex.mem_blocked); end
    tick();
    checks++; if (retire !== 1'b1 || gpr_we !== 1'b0 || ex.mem_blocked !== 1'b0) begin errors++; $display("FAIL wide_retire: ret=%b we=%b blk=%b required 1 0 0", retire, gpr_we, ex.mem_blocked); end
    tick();
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL wide_single_retire: ret=%b required 0", retire); end
  endtask

  task automatic test_back_to_back();
    drive(128'h11, 64'h0, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0); tick();
    checks++; if (ex.mem_blocked !== 1'b1) begin errors++; $display("FAIL b2b_blk_rise: blk=%b required 1", ex.mem_blocked); end
    drive(128'h22, 64'h0, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0); tick(); idle_in();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd1 || gpr_wdata !== 64'h11) begin errors++; $display("FAIL b2b_first: we=%b addr=%h data=%h required 1 1 11", gpr_we, gpr_waddr, gpr_wdata); end
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd2 || gpr_wdata !== 64'h22 || retire !== 1'b1) begin errors++; $display("FAIL b2b_second: we=%b addr=%h data=%h ret=%b required 1 2 22 1", gpr_we, gpr_waddr, gpr_wdata, retire); end
    tick();
    checks++; if (gpr_we !== 1'b0 || retire !== 1'b1 || ex.mem_blocked !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_end: we=%b ret=%b blk=%b ovf=%b required 0 1 0 0", gpr_we, retire, ex.mem_blocked, overflow); end
    tick();
  endtask

  task automatic test_wide_then_narrow();
    drive({64'h50, 64'h40}, 64'h0, 4'd4, 1'b1, 1'b1, 4'd5, 1'b0); tick();
    drive(128'h60, 64'h0, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0); tick(); idle_in();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd4 || gpr_wdata !== 64'h40 || ex.mem_blocked !== 1'b1) begin errors++; $display("FAIL wn_low: we=%b addr=%h data=%h blk=%b required 1 4 40 1", gpr_we, gpr_waddr, gpr_wdata, ex.mem_blocked); end
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd5 || gpr_wdata !== 64'h50 || ex.mem_blocked !== 1'b1) begin errors++; $display("FAIL wn_high: we=%b addr=%h data=%h blk=%b required 1 5 50 1", gpr_we, gpr_waddr, gpr_wdata, ex.mem_blocked); end
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd6 || gpr_wdata !== 64'h60 || retire !== 1'b1) begin errors++; $display("FAIL wn_n1: we=%b addr=%h data=%h ret=%b required 1 6 60 1", gpr_we, gpr_waddr, gpr_wdata, retire); end
    drive(128'h70, 64'h0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0); tick(); idle_in();
    checks++; if (gpr_we !== 1'b0 || retire !== 1'b1 || ex.mem_blocked !== 1'b1) begin errors++; $display("FAIL wn_pushpop: we=%b ret=%b blk=%b required 0 1 1", gpr_we, retire, ex.mem_blocked); end
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd7 || gpr_wdata !== 64'h70 || retire !== 1'b0) begin errors++; $display("FAIL wn_n2: we=%b addr=%h data=%h ret=%b required 1 7 70 0", gpr_we, gpr_waddr, gpr_wdata, retire); end
    tick();
    checks++; if (retire !== 1'b1 || ex.mem_blocked !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL wn_end: ret=%b blk=%b ovf=%b required 1 0 0", retire, ex.mem_blocked, overflow); end
    tick();
  endtask

  task automatic test_overflow();
    drive(128'h80, 64'h0, 4'd8, 1'b1, 1'b0, 4'd0, 1'b0); tick();
    drive(128'h90, 64'h0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0); tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_first: we=%b addr=%h ovf=%b required 1 8 0", gpr_we, gpr_waddr, overflow); end
    drive(128'hA0, 64'h0, 4'd10, 1'b1, 1'b0, 4'd0, 1'b0); tick(); idle_in();
    checks++; if (overflow !== 1'b1 || gpr_waddr !== 4'd9 || gpr_wdata !== 64'h90 || retire !== 1'b1) begin errors++; $display("FAIL ovf_set: ovf=%b addr=%h data=%h ret=%b required 1 9 90 1", overflow, gpr_waddr, gpr_wdata, retire); end
    tick();
    checks++; if (gpr_we !== 1'b0 || retire !== 1'b1 || ex.mem_blocked !== 1'b0) begin errors++; $display("FAIL ovf_drain: we=%b ret=%b blk=%b required 0 1 0", gpr_we, retire, ex.mem_blocked); end
    tick(); tick();
    checks++; if (gpr_we !== 1'b0 || overflow !== 1'b1 || retire !== 1'b0) begin errors++; $display("FAIL ovf_sticky: we=%b ovf=%b ret=%b required 0 1 0", gpr_we, overflow, retire); end
  endtask

  task automatic test_reset_mid_drain();
    drive({64'hBB, 64'hAA}, 64'h7, 4'd1, 1'b1, 1'b1, 4'd2, 1'b1); tick(); idle_in();
    tick(); tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd2 || gpr_wdata !== 64'hBB) begin errors++; $display("FAIL rst_high: we=%b addr=%h data=%h required 1 2 bb", gpr_we, gpr_waddr, gpr_wdata); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (gpr_we !== 1'b0 || gpr_wdata !== 64'd0 || retire !== 1'b0 || overflow !== 1'b0 || ex.mem_blocked !== 1'b0 || rflags_wdata !== 64'd0) begin errors++; $display("FAIL rst_mid: we=%b data=%h ret=%b ovf=%b blk=%b rf=%h required all 0", gpr_we, gpr_wdata, retire, overflow, ex.mem_blocked, rflags_wdata); end
    tick();
    checks++; if (gpr_we !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL rst_abandon: we=%b ret=%b required 0 0", gpr_we, retire); end
    drive(128'h33, 64'h0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0); tick(); idle_in();
    tick();
    checks++; if (gpr_we !== 1'b1 || gpr_waddr !== 4'd3 || gpr_wdata !== 64'h33) begin errors++; $display("FAIL rst_after: we=%b addr=%h data=%h required 1 3 33", gpr_we, gpr_waddr, gpr_wdata); end
    tick();
    checks++; if (retire !== 1'b1 || ex.mem_blocked !== 1'b0) begin errors++; $display("FAIL rst_after_retire: ret=%b blk=%b required 1 0", retire, ex.mem_blocked); end
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_wide();
    test_back_to_back();
    test_wide_then_narrow();
    test_overflow();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_writeback.md
Name: exe_writeback

Overview:
- Stage directly downstream of the execute ALU.
- Buffers completed ALU results in a small FIFO and retires them to the GPR file and RFLAGS through a single 64-bit register write port.
- 128-bit results (wide multiply/divide, upper half to a second register) retire over two cycles.
- Drives the ALU's mem_blocked backpressure input.

Parameters:
- DEPTH, 2, FIFO entries; legal values are 2..8.
- CW, 3, occupancy counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- exe_valid  in  1  ALU result valid this cycle (ALU exe_mem)
- exe_result  in  128  ALU result; [63:0] low half, [127:64] high half
- exe_rflags  in  64  ALU flags result
- exe_dest  in  4  GPR index for the low half
- exe_dest_we  in  1  write low half to exe_dest
- exe_wide  in  1  write high half to exe_dest2
- exe_dest2  in  4  GPR index for the high half
- exe_flags_we  in  1  update RFLAGS
- mem_blocked  out  1  backpressure to the ALU
- gpr_we  out  1  register write strobe
- gpr_waddr  out  4  register write index
- gpr_wdata  out  64  register write data
- rflags_we  out  1  RFLAGS write strobe
- rflags_wdata  out  64  RFLAGS write data
- retire  out  1  one-cycle pulse when an entry completes
- overflow  out  1  sticky error flag: push attempted while full

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - count=0, FSM=IDLE, read/write pointers=0.
  - All outputs 0, including overflow.
  - Reset mid-drain abandons the entry; there is no partial replay.
- Push:
  - Occurs on a posedge with exe_valid=1 and count<DEPTH.
  - Captures {result, rflags, dest, dest_we, wide, dest2, flags_we} into the entry at wptr; wptr wraps modulo DEPTH.
  - exe_valid=1 with count==DEPTH: data dropped, overflow<=1 and held until reset.
- mem_blocked:
  - Combinational: mem_blocked = (count >= DEPTH-1).
  - The ALU samples mem_blocked and registers exe_mem, so at most one push arrives after assertion. The FIFO therefore never overflows under a compliant ALU.
- Drain FSM:
  - IDLE: stays while count==0. If count>0 at a posedge, goes to LOW and registers the head's low-half write:
    - gpr_we <= dest_we
    - gpr_waddr <= dest
    - gpr_wdata <= result[63:0]
    - rflags_we <= flags_we
    - rflags_wdata <= rflags
  - LOW, head wide=1: goes to HIGH and registers gpr_we<=1, gpr_waddr<=dest2, gpr_wdata<=result[127:64], rflags_we<=0.
  - LOW, head wide=0: pops the head and pulses retire<=1. If further entries remain, it loads the next entry's low half in the same edge and stays in LOW; otherwise it goes to IDLE with all strobes <=0.
  - HIGH: pops the head and pulses retire<=1, then reloads the next entry (stays in LOW) or goes to IDLE, as in the LOW wide=0 case.
- Throughput: one narrow entry per cycle; a wide entry takes 2 cycles.
- Every entry consumes at least one cycle, even when dest_we=0 and flags_we=0. In that case the strobes stay 0 and retire still pulses.
- Latency, from an empty buffer:
  - Push at edge E: the head is loaded at E+1, so strobes are high during the cycle after E+1.
  - retire is high during the cycle after E+2 (narrow) or after E+3 (wide).
- Simultaneous push and pop on one edge: count is unchanged and both pointers advance.
- count: +1 on push only, -1 on pop only. It is never negative. A pop is only generated from LOW/HIGH with a valid head.
- Address conflict: if dest==dest2 on a wide entry, both writes are issued in order and the high half is the final value.
- Strobes are registered and held for exactly one cycle per write.
- retire is asserted in the cycle following the last write strobe of an entry.

Test Plan:
- Reset, then a single narrow push (result=0x1234, dest=3, dest_we=1, flags_we=1, rflags=0x46) -> next cycle but one: gpr_we=1, waddr=3, wdata=0x1234, rflags_we=1, rflags_wdata=0x46; retire pulses one cycle later; count returns to 0.
- Wide push (result=0xAAAA_BBBB<<64 | 0xCCCC, dest=0, dest2=2) -> two consecutive write cycles, (0, 0xCCCC) then (2, 0xAAAABBBB); rflags_we is only in the first; exactly one retire pulse.
- Back-to-back narrow pushes each cycle, DEPTH=2 -> mem_blocked rises when count=1; one write per cycle; no overflow; writes in push order.
- A wide entry followed by 2 narrow pushes while draining -> mem_blocked is held during the wide drain; order and data are preserved; pointers wrap correctly.
- Force exe_valid=1 while count==DEPTH -> entry dropped, overflow=1 and sticky; queued entries still retire correctly.
- Assert reset in the HIGH state of a wide drain -> all outputs 0 next cycle, overflow cleared, FIFO empty; a subsequent push drains normally.
